async_fifo_wr_ctrl: RTL and testbench
=====================================

ASYNC_FIFO_WR_CTRL -- requirements
Module: async_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bits per word.
REQ-002 SHALL have parameter BURST_LEN, default 8, maximum words written per burst (range 1..SAFE_GUARD of the downstream FIFO).
REQ-003 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-004 SHALL have port wr_clk, input, 1, write-domain clock.
REQ-005 SHALL have port async_rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port s_data, input, WIDTH, upstream payload.
REQ-007 SHALL have port s_valid, input, 1, upstream word valid.
REQ-008 SHALL have port s_last, input, 1, marks final word of a frame.
REQ-009 SHALL have port s_ready, output, 1, upstream word accepted when s_valid && s_ready.
REQ-010 SHALL have port fifo_data_in, output, WIDTH+1, FIFO write word {s_last, s_data}.
REQ-011 SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-012 SHALL have port fifo_full, input, 1, FIFO full flag (wr_clk domain).
REQ-013 SHALL have port fifo_going_full, input, 1, FIFO near-full flag (wr_clk domain).
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have ports frame_cnt, word_cnt, stall_cnt, output, CNT_W each, statistics.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_ROOM, BURST.
REQ-017 IDLE: s_valid && fifo_going_full -> WAIT_ROOM; s_valid && !fifo_going_full -> BURST; else stay.
REQ-018 WAIT_ROOM: !fifo_going_full -> BURST; else stay; s_ready low throughout.
REQ-019 BURST: s_ready = !fifo_full; fifo_wr_en = s_valid && s_ready (combinational, zero latency); fifo_data_in = {s_last, s_data}.
REQ-020 SHALL hold a beat counter, cleared on BURST entry, incremented on each accepted word.
REQ-021 BURST -> IDLE the cycle after an accepted word that either has s_last=1 or makes beat count equal BURST_LEN; IDLE then re-evaluates, giving exactly one bubble cycle between bursts.
REQ-022 fifo_full high in BURST: no write, s_ready low, state and beat count held; resumes same cycle fifo_full drops.
REQ-023 s_valid low in BURST: no write, state held (no timeout).
REQ-024 fifo_going_full rising mid-burst SHALL NOT end the burst; checked only at IDLE/WAIT_ROOM.
REQ-025 fifo_wr_en SHALL never assert while fifo_full is high or outside BURST.
REQ-026 Beat counter width SHALL be $clog2(BURST_LEN+1); wraps never occur since burst ends at BURST_LEN.

Reset
REQ-027 async_rst_n SHALL feed an internal 2-flop synchronizer: assertion asynchronous, deassertion after 2 wr_clk rising edges.
REQ-028 While internal reset active: state IDLE, beat count 0, s_ready 0, fifo_wr_en 0, busy 0, all counters 0; fifo_data_in don't-care.
REQ-029 Reset mid-burst SHALL abandon the frame: no further writes; next accepted word starts a fresh burst.

Configuration
REQ-030 Macro FIFO_WR_STATS_EN defined: frame_cnt increments per accepted s_last word, word_cnt per accepted word, stall_cnt per cycle with s_valid high and no write while busy; all saturate at 2^CNT_W-1.
REQ-031 Macro FIFO_WR_STATS_EN undefined: counter logic absent; frame_cnt, word_cnt, stall_cnt tied to 0; ports retained.

Verification (WIDTH=8, BURST_LEN=4, stats enabled)
REQ-032 Release reset, s_valid held 0 -> s_ready/fifo_wr_en stay 0 for all cycles; busy 0; counters 0.
REQ-033 10-word frame 0x00..0x09 (s_last on 0x09), FIFO empty -> bursts of 4,4,2 with one bubble cycle between; fifo_data_in last word 0x109; frame_cnt=1, word_cnt=10.
REQ-034 fifo_going_full=1 when s_valid rises -> WAIT_ROOM, no write; drop flag after 5 cycles -> BURST entered next cycle; stall_cnt counts waiting cycles.
REQ-035 fifo_full pulsed 3 cycles after 2nd beat -> writes pause exactly 3 cycles, beat count holds at 2, burst completes with 4 writes total.
REQ-036 async_rst_n asserted on beat 2 of a burst -> fifo_wr_en drops immediately; after deassert plus 2 edges, new frame writes from beat 0, counters restart at 0.
REQ-037 Compile without FIFO_WR_STATS_EN, repeat REQ-033 -> identical fifo traffic, all counters read 0.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side burst controller for an async FIFO: throttles on near-full, bursts up to BURST_LEN words.
// Define FIFO_WR_STATS_EN to build the saturating frame/word/stall counters; otherwise they read 0.
module async_fifo_wr_ctrl #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic             wr_clk,
    input  logic             async_rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH:0]   fifo_data_in,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    input  logic             fifo_going_full,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ROOM, BURST} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_nxt;
    logic [1:0]        rst_sync;
    logic              rst_n;

    // Assert immediately, release only after two clean wr_clk edges.
    always_ff @(posedge wr_clk or negedge async_rst_n) begin
        if (!async_rst_n) rst_sync <= '0;
        else              rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        s_ready    = 1'b0;
        fifo_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nxt = fifo_going_full ? WAIT_ROOM : BURST;
                    beat_nxt  = '0;
                end
            end
            WAIT_ROOM: begin
                if (!fifo_going_full) begin
                    state_nxt = BURST;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                // Near-full is deliberately ignored here; only fifo_full pauses a burst.
                s_ready    = !fifo_full;
                fifo_wr_en = s_valid && !fifo_full;
                if (fifo_wr_en) begin
                    beat_nxt = beat + 1'b1;
                    if (s_last || beat_nxt == BEAT_W'(BURST_LEN)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_data_in = {s_last, s_data};
    assign busy         = (state != IDLE);

`ifdef FIFO_WR_STATS_EN
    logic stall;
    assign stall = busy && s_valid && !fifo_wr_en;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (fifo_wr_en && s_last && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            if (fifo_wr_en && word_cnt != '1)            word_cnt  <= word_cnt + 1'b1;
            if (stall && stall_cnt != '1)                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign frame_cnt = '0;
    assign word_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl: directed scenarios plus randomized frames and FIFO flags.
// Counter expectations follow FIFO_WR_STATS_EN (zero when the macro is undefined).
module tb_async_fifo_wr_ctrl;
    localparam int WIDTH = 8;
    localparam int BL    = 4;
    localparam int CW    = 5;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef FIFO_WR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             wr_clk = 1'b0;
    logic             async_rst_n = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [WIDTH:0]   fifo_data_in;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0;
    logic             fifo_going_full = 1'b0;
    logic             busy;
    logic [CW-1:0]    frame_cnt;
    logic [CW-1:0]    word_cnt;
    logic [CW-1:0]    stall_cnt;

    always #5 wr_clk = ~wr_clk;

    async_fifo_wr_ctrl #(.WIDTH(WIDTH), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .wr_clk(wr_clk), .async_rst_n(async_rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_going_full(fifo_going_full),
        .busy(busy), .frame_cnt(frame_cnt), .word_cnt(word_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct { int f; int w; int s; } snap_t;

    logic [WIDTH:0] expq[$];
    snap_t          snapq[$];
    int  errors = 0;
    int  checks = 0;
    int  tmo_req = 0;
    int  tmo_seen = 0;
    bit  end_req = 1'b0;

    // Reference model: phase 0 idle, 1 waiting for room, 2 bursting.
    int phase = 0, beats = 0, rcnt = 0;
    int m_frames = 0, m_words = 0, m_stalls = 0;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge wr_clk or negedge async_rst_n) begin
        if ($time != 0) begin
            if (wr_clk) begin
                #1;
                chk("rst_wr_en", int'(fifo_wr_en), 0);
                chk("rst_s_ready", int'(s_ready), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_word_cnt", int'(word_cnt), 0);
            end else begin
                bit active, ex_ready, ex_wr;
                logic [WIDTH:0] ew;
                snap_t sn;
                active = !async_rst_n || rcnt < 2;
                if (active) begin
                    phase = 0; beats = 0; m_frames = 0; m_words = 0; m_stalls = 0;
                end
                ex_ready = !active && phase == 2 && !fifo_full;
                ex_wr    = ex_ready && s_valid;
                if (tmo_req != tmo_seen) begin
                    chk("handshake_timeout", tmo_req, tmo_seen);
                    tmo_seen = tmo_req;
                end
                chk("s_ready", int'(s_ready), int'(ex_ready));
                chk("fifo_wr_en", int'(fifo_wr_en), int'(ex_wr));
                chk("busy", int'(busy), int'(!active && phase != 0));
                chk("frame_cnt", int'(frame_cnt), STATS ? m_frames : 0);
                chk("word_cnt", int'(word_cnt), STATS ? m_words : 0);
                chk("stall_cnt", int'(stall_cnt), STATS ? m_stalls : 0);
                if (fifo_wr_en) begin
                    if (expq.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        ew = expq.pop_front();
                        chk("fifo_data_in", int'(fifo_data_in), int'(ew));
                    end
                end
                if (snapq.size() > 0) begin
                    sn = snapq.pop_front();
                    chk("snap_frames", int'(frame_cnt), STATS ? sn.f : 0);
                    chk("snap_words", int'(word_cnt), STATS ? sn.w : 0);
                    chk("snap_stalls", int'(stall_cnt), STATS ? sn.s : 0);
                end
                if (end_req) begin
                    chk("queue_drained", expq.size(), 0);
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $finish;
                end
                if (!active) begin
                    if (ex_wr) begin
                        m_words = sat(m_words + 1);
                        if (s_last) m_frames = sat(m_frames + 1);
                    end
                    if (phase != 0 && s_valid && !ex_wr) m_stalls = sat(m_stalls + 1);
                    if (phase == 0) begin
                        if (s_valid) begin phase = fifo_going_full ? 1 : 2; beats = 0; end
                    end else if (phase == 1) begin
                        if (!fifo_going_full) begin phase = 2; beats = 0; end
                    end else if (ex_wr) begin
                        beats++;
                        if (s_last || beats == BL) phase = 0;
                    end
                end
                if (!async_rst_n) rcnt = 0;
                else if (rcnt < 2) rcnt++;
            end
        end
    end

    // Driver
    bit rand_flags = 1'b0;
    int gf_cnt = 0, full_cnt = 0;

    task automatic step(output bit acc);
        @(negedge wr_clk);
        acc = s_valid && s_ready;
        @(posedge wr_clk);
        #1;
        if (gf_cnt > 0) begin gf_cnt--; if (gf_cnt == 0) fifo_going_full = 1'b0; end
        if (full_cnt > 0) begin full_cnt--; if (full_cnt == 0) fifo_full = 1'b0; end
        if (rand_flags) begin
            fifo_full       = ($urandom_range(0, 3) == 0);
            fifo_going_full = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic send_frame(input int n, input int base, input int full_after,
                              input int abort_at, input int gap_max);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int waited;
            if (gap_max > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) step(acc);
            end
            s_data  = WIDTH'(base + i);
            s_last  = (i == n - 1);
            s_valid = 1'b1;
            expq.push_back({s_last, s_data});
            if (i == abort_at) begin
                #2;
                async_rst_n = 1'b0;
                s_valid = 1'b0;
                s_last  = 1'b0;
                expq.delete();
                return;
            end
            waited = 0;
            acc = 1'b0;
            while (!acc) begin
                step(acc);
                waited++;
                if (!acc && waited > 200) begin
                    tmo_req++;
                    s_valid = 1'b0;
                    expq.delete();
                    return;
                end
            end
            if (i == full_after) begin fifo_full = 1'b1; full_cnt = 3; end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        bit acc;
        repeat (3) @(posedge wr_clk);
        #1 async_rst_n = 1'b1;
        repeat (10) step(acc);                           // idle after reset
        send_frame(10, 'h00, -1, -1, 0);                 // 4,4,2 bursts
        snapq.push_back('{1, 10, 0});
        repeat (2) step(acc);
        fifo_going_full = 1'b1; gf_cnt = 5;              // wait for room
        send_frame(2, 'h20, -1, -1, 0);
        snapq.push_back('{2, 12, 5});
        repeat (2) step(acc);
        send_frame(4, 'h30, 1, -1, 0);                   // full pulse after 2nd beat
        snapq.push_back('{3, 16, 8});
        repeat (2) step(acc);
        send_frame(6, 'h40, -1, 2, 0);                   // reset mid-burst
        repeat (3) @(posedge wr_clk);
        #1 async_rst_n = 1'b1;
        send_frame(3, 'h50, -1, -1, 0);
        snapq.push_back('{1, 3, 0});
        repeat (2) step(acc);
        rand_flags = 1'b1;
        for (int k = 0; k < 40; k++)
            send_frame($urandom_range(1, 9), $urandom_range(0, 255), -1, -1, 2);
        rand_flags = 1'b0;
        fifo_full = 1'b0;
        fifo_going_full = 1'b0;
        repeat (3) step(acc);
        end_req = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
